alu_seq_muldiv: RTL and testbench

//  Parametrised, registered successor of the single-cycle ALU for the MIPS datapath.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_muldiv_iter.sv | 117 +++++++++++
 rtl/alu_seq_muldiv.sv | 159 +++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential MIPS ALU: opcodes, FSM states and
// opcode classification helpers.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [OP_W-1:0] OP_OR    = 5'b00010;
    localparam logic [OP_W-1:0] OP_ORI   = 5'b00011;
    localparam logic [OP_W-1:0] OP_SRL   = 5'b00100;
    localparam logic [OP_W-1:0] OP_SLL   = 5'b00101;
    localparam logic [OP_W-1:0] OP_LUI   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ANDI  = 5'b00111;
    localparam logic [OP_W-1:0] OP_NOR   = 5'b01100;
    localparam logic [OP_W-1:0] OP_AND   = 5'b01101;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b01110;
    localparam logic [OP_W-1:0] OP_SRA   = 5'b01111;
    localparam logic [OP_W-1:0] OP_SLT   = 5'b10000;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'b10001;
    localparam logic [OP_W-1:0] OP_MULT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_MULTU = 5'b10011;
    localparam logic [OP_W-1:0] OP_DIV   = 5'b10100;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'b10101;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Multi-cycle operations that run through the iterative unit
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: one product or quotient bit per step on
// magnitudes, with sign correction applied combinationally on the result.
//  clk, reset   clock, synchronous active-high reset
//  load         capture operands and signedness, arm counter to WIDTH
//  step         perform one iteration and decrement the counter
//  op_div       1 = divide, 0 = multiply (captured on load)
//  op_signed    signed operation (captured on load)
//  a, b         operands (captured on load)
//  last_c       counter is 1: the current step is the final one
//  div_zero     divide had a zero divisor (registered)
//  hi_c, lo_c   sign-corrected HI/LO result of the finished operation
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_c,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q;     // product upper half / partial remainder
    logic [WIDTH-1:0] sh_q;      // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] m_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw_q;   // original dividend, returned as HI on divide-by-zero
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             neg_q;     // product / quotient must be negated
    logic             neg_r;     // remainder must be negated (dividend sign)

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add: conditionally add multiplicand, then shift {acc, sh} right
    assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);

    // Restoring divide: shift next dividend bit in, trial-subtract divisor
    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};

    assign last_c = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            sh_q     <= '0;
            m_q      <= '0;
            a_raw_q  <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc_q    <= '0;
            sh_q     <= a_mag;
            m_q      <= b_mag;
            a_raw_q  <= a;
            cnt_q    <= CNT_W'(WIDTH);
            is_div_q <= op_div;
            neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= op_signed & a[WIDTH-1];
            div_zero <= op_div & (b == '0);
        end else if (step) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div_q) begin
                if (!div_diff[WIDTH]) begin
                    acc_q <= div_diff[WIDTH-1:0];
                    sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_q <= div_shift[WIDTH-1:0];
                    sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_q <= mul_sum[WIDTH:1];
                sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    // Sign fix and divide-by-zero override on the finished magnitudes
    always_comb begin
        prod     = {acc_q, sh_q};
        prod_fix = neg_q ? -prod : prod;
        hi_c     = prod_fix[2*WIDTH-1:WIDTH];
        lo_c     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero) begin
                lo_c = '1;
                hi_c = a_raw_q;
            end else begin
                lo_c = neg_q ? -sh_q : sh_q;
                hi_c = neg_r ? -acc_q : acc_q;
            end
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered MIPS ALU with iterative MULT/MULTU/DIV/DIVU into HI/LO and a
// start/busy/done handshake for stalling the datapath.
//  clk, reset        clock, synchronous active-high reset
//  start_i           issue operation (ignored while busy_o)
//  alu_operation_i   5-bit opcode
//  a_i, b_i          operands rs, rt (shifts operate on b_i)
//  shamt_i           shift amount
//  imm_i             immediate for ORI/ANDI/LUI
//  busy_o            multi-cycle operation in progress
//  done_o            one-cycle result-valid pulse
//  alu_data_o        registered result; zero_o flags it is zero
//  overflow_o        signed overflow of ADD/SUB
//  div_zero_o        last divide had a zero divisor
//  hi_o, lo_o        HI/LO registers
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [4:0]         alu_operation_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH/2-1:0] imm_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   alu_data_o,
    output logic               zero_o,
    output logic               overflow_o,
    output logic               div_zero_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam int unsigned HALF = WIDTH / 2;

    state_t           state;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             md_div_zero;
    logic [WIDTH-1:0] md_hi_c;
    logic [WIDTH-1:0] md_lo_c;

    assign imm_ext = {{HALF{1'b0}}, imm_i};
    assign sum     = a_i + b_i;
    assign diff    = a_i - b_i;

    assign load_c = (state == ST_IDLE) && start_i && is_muldiv(alu_operation_i);
    assign step_c = (state == ST_MUL) || (state == ST_DIV);

    // Single-cycle datapath
    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (alu_operation_i)
            OP_ADD: begin
                res_c = sum;
                ovf_c = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = diff;
                ovf_c = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_OR:   res_c = a_i | b_i;
            OP_ORI:  res_c = a_i | imm_ext;
            OP_SRL:  res_c = b_i >> shamt_i;
            OP_SLL:  res_c = b_i << shamt_i;
            OP_LUI:  res_c = {imm_i, {HALF{1'b0}}};
            OP_ANDI: res_c = a_i & imm_ext;
            OP_NOR:  res_c = ~(a_i | b_i);
            OP_AND:  res_c = a_i & b_i;
            OP_XOR:  res_c = a_i ^ b_i;
            OP_SRA:  res_c = WIDTH'($signed(b_i) >>> shamt_i);
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_MFHI: res_c = hi_o;
            OP_MFLO: res_c = lo_o;
            default: res_c = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .step      (step_c),
        .op_div    (is_div(alu_operation_i)),
        .op_signed (is_signed_md(alu_operation_i)),
        .a         (a_i),
        .b         (b_i),
        .last_c    (last_c),
        .div_zero  (md_div_zero),
        .hi_c      (md_hi_c),
        .lo_c      (md_lo_c)
    );

    // Control FSM with registered outputs, HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            alu_data_o <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (is_muldiv(alu_operation_i)) begin
                            state      <= is_div(alu_operation_i) ? ST_DIV : ST_MUL;
                            busy_o     <= 1'b1;
                            div_zero_o <= 1'b0;
                        end else begin
                            alu_data_o <= res_c;
                            zero_o     <= (res_c == '0);
                            overflow_o <= ovf_c;
                            done_o     <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_c) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    hi_o       <= md_hi_c;
                    lo_o       <= md_lo_c;
                    alu_data_o <= md_lo_c;
                    zero_o     <= (md_lo_c == '0);
                    overflow_o <= 1'b0;
                    div_zero_o <= md_div_zero;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Randomized self-checking bench for alu_seq_muldiv against an arithmetic reference model.
module tb_alu_seq_muldiv;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [4:0]    alu_operation_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [4:0]    shamt_i;
    logic [15:0]   imm_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  alu_data_o;
    logic          zero_o;
    logic          overflow_o;
    logic          div_zero_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .imm_i           (imm_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .alu_data_o      (alu_data_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o),
        .div_zero_o      (div_zero_o),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Single-cycle reference: plain wide-integer arithmetic
    function automatic void model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh, input logic [15:0] imm,
                                     output logic [31:0] res, output logic ovf);
        longint s;
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_OR:   res = a | b;
            OP_ORI:  res = a | {16'h0, imm};
            OP_SRL:  res = b >> sh;
            OP_SLL:  res = b << sh;
            OP_LUI:  res = {imm, 16'h0};
            OP_ANDI: res = a & {16'h0, imm};
            OP_NOR:  res = ~(a | b);
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_SRA:  res = 32'($signed(b) >>> sh);
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            default: res = '0;
        endcase
    endfunction

    // Mul/div reference: 64-bit products, truncating division
    function automatic void model_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint q;
        longint r;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                p  = 64'(longint'($signed(a)) * longint'($signed(b)));
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1'b1;
                end else if (op == OP_DIV) begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one operation in the current cycle and check its outcome
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [15:0] imm);
        logic [31:0] er;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        eo;
        logic        edz;
        logic        bad;
        int          edge_n;
        start_i         = 1'b1;
        alu_operation_i = op;
        a_i             = a;
        b_i             = b;
        shamt_i         = sh;
        imm_i           = imm;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (is_muldiv(op)) begin
            model_md(op, a, b, ehi, elo, edz);
            edge_n = 1;
            bad    = 1'b0;
            while (!done_o && edge_n < 100) begin
                if (busy_o !== 1'b1) bad = 1'b1;
                @(posedge clk); #1;
                edge_n++;
            end
            check({tag, " busy held"}, 64'(bad), 64'd0);
            check({tag, " done edge"}, 64'(edge_n), 64'(W + 2));
            check({tag, " busy at done"}, 64'(busy_o), 64'd0);
            check({tag, " hi"}, 64'(hi_o), 64'(ehi));
            check({tag, " lo"}, 64'(lo_o), 64'(elo));
            check({tag, " data"}, 64'(alu_data_o), 64'(elo));
            check({tag, " zero"}, 64'(zero_o), 64'(elo == 32'h0));
            check({tag, " divzero"}, 64'(div_zero_o), 64'(edz));
            m_hi = ehi;
            m_lo = elo;
            m_dz = edz;
        end else begin
            model_op(op, a, b, sh, imm, er, eo);
            check({tag, " done"}, 64'(done_o), 64'd1);
            check({tag, " busy"}, 64'(busy_o), 64'd0);
            check({tag, " data"}, 64'(alu_data_o), 64'(er));
            check({tag, " zero"}, 64'(zero_o), 64'(er == 32'h0));
            check({tag, " ovf"}, 64'(overflow_o), 64'(eo));
            check({tag, " divzero hold"}, 64'(div_zero_o), 64'(m_dz));
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [4:0] op;
        int         edge_n;
        logic       saw_done;

        reset           = 1'b1;
        start_i         = 1'b0;
        alu_operation_i = '0;
        a_i             = '0;
        b_i             = '0;
        shamt_i         = '0;
        imm_i           = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset data", 64'(alu_data_o), 64'd0);
        check("reset hilo", {hi_o, lo_o}, 64'd0);
        check("reset flags", 64'({zero_o, overflow_o, div_zero_o}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        run_op("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 16'h0);
        check("add ovf const", {31'h0, overflow_o, alu_data_o}, {31'h0, 1'b1, 32'h8000_0000});
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 16'h0);
        check("mult const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 16'h0);
        check("multu const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 16'h0);
        check("div const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu by 0", OP_DIVU, 32'd7, 32'd0, 5'd0, 16'h0);
        check("divu0 const", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
        run_op("mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 16'h0);
        run_op("div min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 16'h0);
        check("div min const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        run_op("div neg 0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd0, 16'h0);
        run_op("sra", OP_SRA, 32'h0, 32'h8000_0000, 5'd4, 16'h0);
        check("sra const", 64'(alu_data_o), 64'hF800_0000);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'h0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'h0);
        run_op("sub zero", OP_SUB, 32'd5, 32'd5, 5'd0, 16'h0);
        check("sub zero const", 64'(zero_o), 64'd1);
        run_op("sub ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 16'h0);
        run_op("ori", OP_ORI, 32'h1234_0000, 32'h0, 5'd0, 16'hBEEF);
        run_op("andi", OP_ANDI, 32'hFFFF_FFFF, 32'h0, 5'd0, 16'h8001);
        run_op("lui", OP_LUI, 32'h0, 32'h0, 5'd0, 16'hABCD);
        run_op("bad op", 5'b11011, 32'h5, 32'h6, 5'd1, 16'h1);

        // start_i while busy is ignored
        start_i = 1'b1; alu_operation_i = OP_MULT; a_i = 32'd6; b_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        edge_n  = 1;
        repeat (3) begin @(posedge clk); #1; edge_n++; end
        start_i = 1'b1; alu_operation_i = OP_ADD; a_i = 32'd1; b_i = 32'd1;
        @(posedge clk); #1;
        edge_n++;
        start_i = 1'b0;
        check("ignore busy", 64'(busy_o), 64'd1);
        check("ignore no done", 64'(done_o), 64'd0);
        while (!done_o && edge_n < 100) begin @(posedge clk); #1; edge_n++; end
        check("ignore done edge", 64'(edge_n), 64'd34);
        check("ignore data", 64'(alu_data_o), 64'h2A);
        m_hi = 32'h0; m_lo = 32'h2A; m_dz = 1'b0;
        run_op("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 16'h0);
        @(posedge clk); #1;
        check("no late add", 64'(done_o), 64'd0);

        // Reset in the middle of a multiply
        start_i = 1'b1; alu_operation_i = OP_MULTU; a_i = 32'h0001_2345; b_i = 32'h0000_0777;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 64'(busy_o), 64'd0);
        check("abort hilo", {hi_o, lo_o}, 64'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'd0);

        // Randomized back-to-back traffic
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 1) == 0) op = OP_MULT + 5'($urandom_range(0, 3));
            else                           op = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d op%0h", i, op), op, rand_operand(), rand_operand(),
                   5'($urandom_range(0, 31)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check("idle done", 64'(done_o), 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
